mac_result_collector: RTL and testbench
=======================================

# mac_result_collector

Consumer-side endpoint of the `top_system` MAC output interface. It watches the per-MAC `valid_out` strobes and `acc_out_*` values and captures every result on its rising strobe edge. Each result is tagged with MAC index and phase (loading/layering), queued in a FIFO and presented to a downstream reader over a valid/ready handshake. It sits directly after `top_system` and replaces ad-hoc edge-waiting on `valid_out` in benches and in the host-side readout path.

## Interface
- ACC_W, 16, accumulator width (matches `top_system` ACC_W)
- N_MACS, 4, number of MAC lanes; ID_W = $clog2(N_MACS)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- clk  in  1  clock; one clock domain, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush (FIFO, pending, overflow)
- valid_in  in  N_MACS  connects to `valid_out`; bit i qualifies MAC i
- acc_in  in  N_MACS*ACC_W  concatenated `acc_out_*`; slice [i*ACC_W +: ACC_W] = MAC i
- phase_layer  in  1  0 = loading phase, 1 = layering phase; sampled with the capture
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  ACC_W  head result (signed, passed through unmodified)
- out_mac_id  out  ID_W  head MAC index
- out_layer  out  1  head phase tag
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a result was lost
- busy  out  1  any pending capture or FIFO non-empty

## Operation
- Edge detect: register prev[i] <= valid_in[i] every cycle. Capture condition cap[i] = valid_in[i] & ~prev[i]. A held-high strobe captures once.
- Capture stage: per lane, hold_data[i], hold_layer[i], pending[i]. On cap[i]: hold <= acc slice and phase_layer, pending[i] <= 1.
- Arbiter: fixed priority, lowest index pending first. One push per cycle.
- Push allowed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle. On push, pending[sel] clears unless cap[sel] in the same cycle. In that case the new value loads, pending stays 1, and no overflow is flagged.
- Overflow: cap[i] while pending[i]=1 and lane i not pushed this cycle. New value overwrites the old one and overflow <= 1. Overflow stays set until rst or clear.
- FIFO full: pending lanes wait. No data is dropped except by overwrite as above.
- Pop: out_valid & out_ready. out_data/out_mac_id/out_layer are driven combinationally from the head entry. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged. When empty, push and pop do not coincide because out_valid=0.
- clear (synchronous, takes priority over push/pop/capture):
  - rd/wr pointers, count, pending and overflow are cleared.
  - prev <= valid_in, so a strobe already high does not re-trigger.
- busy = |pending | (count != 0).

## Timing
- Reset values: out_valid 0, out_data 0, out_mac_id 0, out_layer 0, count 0, overflow 0, busy 0. Internally, prev = 0 and pending = 0.
- rst asserted mid-operation: all contents are discarded immediately. If valid_in is still high after release, it captures on the first clock (prev = 0).
- Latency: valid_in[i] rises and is sampled at posedge k, which sets pending at k. The push happens at k+1, if no higher-priority lane is pending and the FIFO is not full. out_valid is high after k+1, so 2 cycles when the FIFO is empty.
- Two lanes rising at the same posedge: lower index pushed at k+1, higher at k+2.
- out_valid holds and head fields are stable until popped. out_ready may be high with out_valid low, and this has no effect.
- Throughput: 1 result/cycle sustained in and out.

## Test plan
- Load-phase capture: phase_layer=0. valid_in[0] rises with acc0=20, then two cycles later valid_in[1] rises with acc1=30; out_ready=1. Required: out_valid pulses twice, carrying (20, id 0, layer 0) then (30, id 1, layer 0); each appears 2 cycles after its edge; overflow stays 0.
- Simultaneous edges: valid_in=4'b1100 in one cycle with acc2=50, acc3=70, phase_layer=1, out_ready=0. Required: count reaches 2 at k+2. The FIFO holds (50, id 2, layer 1) at the head, then (70, id 3, layer 1). busy stays 1 until both are popped.
- Full back-pressure: out_ready=0. Issue 8 single-lane edges with values 1..8, then a 9th edge on lane 0 (value 9). Required: count=8 and pending[0]=1. Raising out_ready then drains 1..9 in order with overflow 0.
- Overflow: with the FIFO full and pending[1] set (value 11), a second edge on lane 1 carries 12. Required: overflow=1 (sticky), and 12 is delivered while 11 is lost. clear then sets overflow=0 and count=0.
- Held strobe and clear: valid_in[0] is held high 5 cycles, so exactly one entry is captured. Assert clear while it is still high. Required: FIFO empties and no re-capture occurs after clear deasserts.
- Async reset mid-stream: assert rst between clock edges while count=3. Required: out_valid, count and busy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mac_result_collector.sv
// Collects MAC results on rising valid strobes, tags them with lane and phase,
// and queues them for a downstream valid/ready reader.
module mac_result_collector #(
   parameter  int ACC_W  = 16,
   parameter  int N_MACS = 4,
   parameter  int DEPTH  = 8,
   localparam int ID_W   = (N_MACS > 1) ? $clog2(N_MACS) : 1,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic [N_MACS-1:0]       valid_in,
   input  logic [N_MACS*ACC_W-1:0] acc_in,
   input  logic                    phase_layer,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic [ID_W-1:0]         out_mac_id,
   output logic                    out_layer,
   output logic [CNT_W-1:0]        count,
   output logic                    overflow,
   output logic                    busy
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [N_MACS-1:0]       prev_p0;
   logic [N_MACS-1:0]       cap_p0;
   logic [N_MACS-1:0]       vld_p1;
   logic signed [ACC_W-1:0] hold_data_p1 [N_MACS];
   logic [N_MACS-1:0]       hold_layer_p1;

   logic signed [ACC_W-1:0] mem_data  [DEPTH];
   logic [ID_W-1:0]         mem_id    [DEPTH];
   logic                    mem_layer [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [ID_W-1:0]  sel;
   logic             any_pend;
   logic             full;
   logic             push;
   logic             pop;

   assign cap_p0 = valid_in & ~prev_p0;

   // Fixed priority: the lowest pending lane wins the single push slot.
   always_comb begin
      sel = '0;
      for (int i = N_MACS - 1; i >= 0; i--) begin
         if (vld_p1[i]) sel = ID_W'(i);
      end
   end

   assign any_pend = |vld_p1;
   assign full     = (count == CNT_W'(DEPTH));
   assign pop      = out_valid & out_ready & ~clear;
   assign push     = any_pend & (~full | pop) & ~clear;

   // ---- stage p0 -> p1: per-lane capture holding registers ----
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_MACS; i++) begin
         if (cap_p0[i] && !clear) begin
            hold_data_p1[i]  <= $signed(acc_in[i*ACC_W +: ACC_W]);
            hold_layer_p1[i] <= phase_layer;
         end
      end
   end

   // ---- stage p1 -> fifo: storage written from the arbitrated lane ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr]  <= hold_data_p1[sel];
         mem_id[wr_ptr]    <= sel;
         mem_layer[wr_ptr] <= hold_layer_p1[sel];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_p0  <= '0;
         vld_p1   <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (clear) begin
         // Track the live strobes so a level already high is not seen as an edge.
         prev_p0  <= valid_in;
         vld_p1   <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         prev_p0 <= valid_in;
         for (int i = 0; i < N_MACS; i++) begin
            if (push && (int'(sel) == i)) begin
               vld_p1[i] <= cap_p0[i];
            end else if (cap_p0[i]) begin
               vld_p1[i] <= 1'b1;
               if (vld_p1[i]) overflow <= 1'b1;
            end
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head fields read as zero while empty so idle outputs are defined.
   assign out_valid  = (count != '0);
   assign out_data   = out_valid ? mem_data[rd_ptr]  : '0;
   assign out_mac_id = out_valid ? mem_id[rd_ptr]    : '0;
   assign out_layer  = out_valid ? mem_layer[rd_ptr] : 1'b0;
   assign busy       = any_pend | out_valid;

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: capture, ordering, back-pressure,
// overflow, held strobes, clear and asynchronous reset.
module tb_mac_result_collector;

   logic               clk = 1'b0;
   logic               rst;
   logic               clear;
   logic [3:0]         valid_in;
   logic [63:0]        acc_in;
   logic               phase_layer;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic [1:0]         out_mac_id;
   logic               out_layer;
   logic [3:0]         count;
   logic               overflow;
   logic               busy;

   int n_cmp = 0;
   int n_bad = 0;

   mac_result_collector #(.ACC_W(16), .N_MACS(4), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .acc_in(acc_in),
      .phase_layer(phase_layer), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_mac_id(out_mac_id), .out_layer(out_layer),
      .count(count), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_acc(input int lane, input int val);
      acc_in[lane*16 +: 16] = 16'(val);
   endtask

   task automatic fill8(input int base);
      for (int n = 1; n <= 8; n++) begin
         set_acc((n - 1) % 4, base + n);
         valid_in = 4'(1 << ((n - 1) % 4));
         tick();
         valid_in = '0;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; valid_in = '0; acc_in = '0;
      phase_layer = 1'b0; out_ready = 1'b0;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b need 0", out_valid); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d need 0", count); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_cmp++; if (out_data !== 16'sd0) begin n_bad++; $display("FAIL rst_out_data: got %0d need 0", out_data); end
      n_cmp++; if (out_mac_id !== 2'd0) begin n_bad++; $display("FAIL rst_mac_id: got %0d need 0", out_mac_id); end
      n_cmp++; if (out_layer !== 1'b0) begin n_bad++; $display("FAIL rst_layer: got %0b need 0", out_layer); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %0b need 0", overflow); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b need 0", busy); end
   endtask

   task automatic test_load_capture();
      phase_layer = 1'b0; out_ready = 1'b1;
      set_acc(0, 20); valid_in = 4'b0001;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL load_early: got %0b need 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'sd20 || out_mac_id !== 2'd0 || out_layer !== 1'b0) begin
         n_bad++; $display("FAIL load_first: got v%0b d%0d id%0d l%0b need v1 d20 id0 l0", out_valid, out_data, out_mac_id, out_layer); end
      set_acc(1, 30); valid_in = 4'b0010;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL load_gap: got %0b need 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'sd30 || out_mac_id !== 2'd1 || out_layer !== 1'b0) begin
         n_bad++; $display("FAIL load_second: got v%0b d%0d id%0d l%0b need v1 d30 id1 l0", out_valid, out_data, out_mac_id, out_layer); end
      valid_in = '0;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL load_drained: got v%0b c%0d need v0 c0", out_valid, count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL load_overflow: got %0b need 0", overflow); end
      out_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      phase_layer = 1'b1; out_ready = 1'b0;
      set_acc(2, 50); set_acc(3, 70); valid_in = 4'b1100;
      tick();
      valid_in = '0; phase_layer = 1'b0;
      tick();
      n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL sim_count_k1: got %0d need 1", count); end
      tick();
      n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL sim_count_k2: got %0d need 2", count); end
      n_cmp++; if (out_data !== 16'sd50 || out_mac_id !== 2'd2 || out_layer !== 1'b1) begin
         n_bad++; $display("FAIL sim_head0: got d%0d id%0d l%0b need d50 id2 l1", out_data, out_mac_id, out_layer); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_data !== 16'sd70 || out_mac_id !== 2'd3 || out_layer !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL sim_head1: got d%0d id%0d l%0b b%0b need d70 id3 l1 b1", out_data, out_mac_id, out_layer, busy); end
      tick();
      n_cmp++; if (busy !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL sim_idle: got b%0b c%0d need b0 c0", busy, count); end
      out_ready = 1'b0;
   endtask

   task automatic test_full_backpressure();
      out_ready = 1'b0;
      fill8(0);
      set_acc(0, 9); valid_in = 4'b0001;
      tick();
      valid_in = '0;
      tick();
      n_cmp++; if (count !== 4'd8 || busy !== 1'b1) begin n_bad++; $display("FAIL full_count: got c%0d b%0b need c8 b1", count, busy); end
      out_ready = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(n) || out_mac_id !== 2'((n - 1) % 4)) begin
            n_bad++; $display("FAIL full_drain%0d: got v%0b d%0d id%0d need v1 d%0d id%0d", n, out_valid, out_data, out_mac_id, n, (n - 1) % 4); end
         tick();
      end
      n_cmp++; if (count !== 4'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL full_end: got c%0d o%0b need c0 o0", count, overflow); end
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      fill8(100);
      set_acc(1, 11); valid_in = 4'b0010;
      tick();
      valid_in = '0;
      tick();
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %0b need 0", overflow); end
      set_acc(1, 12); valid_in = 4'b0010;
      tick();
      valid_in = '0;
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b need 1", overflow); end
      tick();
      out_ready = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         n_cmp++; if (out_data !== 16'(100 + n)) begin n_bad++; $display("FAIL ovf_drain%0d: got %0d need %0d", n, out_data, 100 + n); end
         tick();
      end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'sd12 || out_mac_id !== 2'd1) begin
         n_bad++; $display("FAIL ovf_survivor: got v%0b d%0d id%0d need v1 d12 id1", out_valid, out_data, out_mac_id); end
      tick();
      out_ready = 1'b0;
      n_cmp++; if (count !== 4'd0 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got c%0d o%0b need c0 o1", count, overflow); end
      set_acc(2, 5); valid_in = 4'b0100;
      tick();
      valid_in = '0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++; if (count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clear: got c%0d o%0b b%0b need c0 o0 b0", count, overflow, busy); end
   endtask

   task automatic test_held_strobe_clear();
      out_ready = 1'b0;
      set_acc(0, 77); valid_in = 4'b0001;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (count !== 4'd1 || out_data !== 16'sd77) begin n_bad++; $display("FAIL held_once: got c%0d d%0d need c1 d77", count, out_data); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL held_clear: got c%0d v%0b need c0 v0", count, out_valid); end
      tick(); tick();
      n_cmp++; if (count !== 4'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL held_norecap: got c%0d b%0b need c0 b0", count, busy); end
      valid_in = '0;
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; phase_layer = 1'b0;
      set_acc(0, 1); set_acc(1, 2); set_acc(2, 3); valid_in = 4'b0111;
      tick();
      valid_in = '0;
      tick(); tick(); tick();
      n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL arst_pre: got %0d need 3", count); end
      #2;
      rst = 1'b1;
      set_acc(3, 44); valid_in = 4'b1000;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || out_data !== 16'sd0) begin
         n_bad++; $display("FAIL arst_immediate: got v%0b c%0d b%0b d%0d need v0 c0 b0 d0", out_valid, count, busy, out_data); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_cmp++; if (count !== 4'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL arst_recap: got c%0d b%0b need c0 b1", count, busy); end
      tick();
      n_cmp++; if (count !== 4'd1 || out_data !== 16'sd44 || out_mac_id !== 2'd3) begin
         n_bad++; $display("FAIL arst_after: got c%0d d%0d id%0d need c1 d44 id3", count, out_data, out_mac_id); end
      valid_in = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load_capture();
      test_simultaneous();
      test_full_backpressure();
      test_overflow();
      test_held_strobe_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
